md_clk_enables: RTL and testbench
=================================

# md_clk_enables

Master-clock enable generator and core-reset sequencer for the Mega Drive core. It runs on the PLL's ~53.85 MHz main output (CLKOUT0, MD master clock MCLK) and holds the emulated core in reset until a fixed settle time has elapsed, because the PLL lock is not exported. It then emits the single-cycle clock enables for the 68000/YM2612, Z80, PSG and VDP pixel from MCLK. It also provides a pause handshake that freezes all enables on a 68000 cycle boundary.

## Interface
- STARTUP_CYCLES, default 1024: MCLK cycles after reset release during which core_reset stays high; legal range 2..65535.
- clk  in  1  MCLK, the PLL CLKOUT0 domain; the only clock.
- reset  in  1  synchronous, active-high.
- h40  in  1  1 = H40 mode (pixel = MCLK/8); 0 = H32 mode (pixel = MCLK/10).
- pause_req  in  1  level request to freeze the core.
- core_reset  out  1  reset for all emulated chips; registered.
- ce_68k  out  1  one-cycle pulse at MCLK/7; shared by the 68000 and YM2612.
- ce_z80  out  1  one-cycle pulse at MCLK/15.
- ce_psg  out  1  one-cycle pulse at MCLK/240 (Z80 clock/16).
- ce_pix  out  1  one-cycle pulse at MCLK/8 or MCLK/10.
- paused  out  1  high while the enables are frozen.

## Operation
- States: STARTUP, RUN, PAUSED. reset forces STARTUP from any state, including mid-pause.
- STARTUP:
  - A 16-bit settle counter increments each cycle.
  - After STARTUP_CYCLES cycles with reset low, go to RUN.
  - All division counters are held at 0 and all ce are low.
  - pause_req is ignored.
- Division counters in RUN:
  - c68 counts 0..6, and ce_68k fires on the wrap.
  - cz80 counts 0..14, and ce_z80 fires on the wrap.
  - cpsg counts 0..15 and advances only on ce_z80 cycles; ce_psg fires when cz80 and cpsg wrap together.
  - cpix counts 0..7 (H40) or 0..9 (H32), and ce_pix fires on the wrap.
- h40 is sampled only on a cpix wrap. A new mode applies from the following pixel period; a period in progress is never shortened or stretched.
- RUN -> PAUSED: pause_req is sampled high on a cycle where ce_68k is high. That ce_68k, and any other ce coincident with it, still fire.
- In PAUSED:
  - All counters hold their values.
  - All ce are low.
  - paused = 1.
- PAUSED -> RUN: pause_req is sampled low. Counters resume from their held values; no counts are lost or duplicated.
- All cycle-to-enable spacing excludes STARTUP and PAUSED cycles.

## Timing
- Reset values: state STARTUP, all counters 0, core_reset = 1, every ce = 0, paused = 0.
- Cycle numbering: cycle 0 is the first cycle with reset low. core_reset is low from cycle STARTUP_CYCLES onward; call that cycle R.
- First pulses after R:
  - ce_68k at R+6, then every 7 cycles.
  - ce_z80 at R+14, then every 15 cycles.
  - ce_psg at R+239, then every 240 cycles.
  - ce_pix at R+7 (H40) or R+9 (H32), then every 8 or 10 cycles.
- All outputs are registered. Each ce is high for exactly one cycle per period, and never two consecutive cycles.
- Pause entry: with pause_req high on ce_68k cycle P, paused = 1 from cycle P+1 and no ce fires from P+1.
- Pause exit: with pause_req sampled low on cycle Q while paused, paused = 0 on cycle Q+1 and counting resumes on Q+1. The next ce_68k comes on the 7th non-paused cycle after P.
- pause_req dropping before any ce_68k occurs produces no pause.
- reset asserted mid-run or mid-pause: core_reset = 1, paused = 0 and all ce = 0 on the next cycle.

## Test plan
- Startup: STARTUP_CYCLES=16, release reset at cycle 0 -> core_reset falls at cycle 16; ce_68k at 22, 29, 36; ce_z80 at 30, 45; ce_psg at 255.
- Pixel mode switch: h40=1 -> ce_pix at R+7, R+15. Flip h40 to 0 at R+10 -> next ce_pix at R+23 (old period completes), then R+33.
- Pause: raise pause_req at R+8 -> ce_68k still at R+13, paused = 1 at R+14. Hold 20 cycles, drop pause_req -> next ce_68k exactly 7 active cycles after R+13. Z80 phase preserved: ce_z80 arrives 15 active cycles after R+14.
- Short pause_req pulse: pulse high for cycles R+1..R+3 -> no pause; enables unchanged.
- Reset during pause: assert reset for 1 cycle while paused -> next cycle core_reset = 1, paused = 0, all ce = 0; full STARTUP_CYCLES sequence repeats.
- Long run: 100000 RUN cycles -> counts ce_68k = 14285, ce_z80 = 6666, ce_psg = 416, ce_pix (H40) = 12500; no back-to-back pulses.

Source files
------------

// File: rtl/md_clk_enables.sv
// Mega Drive master-clock enable generator: holds the core in reset for a fixed
// settle time, then emits 68000/Z80/PSG/pixel clock enables with a pause handshake.
module md_clk_enables #(
   parameter int unsigned STARTUP_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic h40,
   input  logic pause_req,
   output logic core_reset,
   output logic ce_68k,
   output logic ce_z80,
   output logic ce_psg,
   output logic ce_pix,
   output logic paused
);

   localparam int unsigned SETTLE_W = 16;
   localparam int unsigned C68_W    = 3;
   localparam int unsigned CZ80_W   = 4;
   localparam int unsigned CPSG_W   = 4;
   localparam int unsigned CPIX_W   = 4;

   localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(STARTUP_CYCLES - 1);
   localparam logic [C68_W-1:0]    C68_LAST     = C68_W'(6);
   localparam logic [CZ80_W-1:0]   CZ80_LAST    = CZ80_W'(14);
   localparam logic [CPSG_W-1:0]   CPSG_LAST    = CPSG_W'(15);
   localparam logic [CPIX_W-1:0]   PIX_LAST_H40 = CPIX_W'(7);
   localparam logic [CPIX_W-1:0]   PIX_LAST_H32 = CPIX_W'(9);

   typedef enum logic [1:0] {
      STARTUP = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   state_t              state,    state_d;
   logic [SETTLE_W-1:0] settle,   settle_d;
   logic [C68_W-1:0]    c68,      c68_d;
   logic [CZ80_W-1:0]   cz80,     cz80_d;
   logic [CPSG_W-1:0]   cpsg,     cpsg_d;
   logic [CPIX_W-1:0]   cpix,     cpix_d;
   logic                mode_cur, mode_cur_d;
   logic                mode_nxt, mode_nxt_d;
   logic [CPIX_W-1:0]   pix_last, pix_last_d;
   logic                run_d;
   logic                ce_68k_d, ce_z80_d, ce_psg_d, ce_pix_d;

   // Next-state and counter advance; the pixel mode is pipelined one period deep
   // so a period that has already started is never resized.
   always_comb begin
      state_d    = state;
      settle_d   = settle;
      c68_d      = c68;
      cz80_d     = cz80;
      cpsg_d     = cpsg;
      cpix_d     = cpix;
      mode_cur_d = mode_cur;
      mode_nxt_d = mode_nxt;
      pix_last   = mode_cur ? PIX_LAST_H40 : PIX_LAST_H32;

      case (state)
         STARTUP: begin
            settle_d   = settle + SETTLE_W'(1);
            c68_d      = '0;
            cz80_d     = '0;
            cpsg_d     = '0;
            cpix_d     = '0;
            mode_cur_d = h40;
            mode_nxt_d = h40;
            if (settle == SETTLE_LAST) begin
               state_d  = RUN;
               settle_d = '0;
            end
         end

         RUN: begin
            c68_d  = (c68 == C68_LAST)   ? '0 : c68 + C68_W'(1);
            cz80_d = (cz80 == CZ80_LAST) ? '0 : cz80 + CZ80_W'(1);
            if (cz80 == CZ80_LAST) begin
               cpsg_d = (cpsg == CPSG_LAST) ? '0 : cpsg + CPSG_W'(1);
            end
            if (cpix == pix_last) begin
               cpix_d     = '0;
               mode_cur_d = mode_nxt;
               mode_nxt_d = h40;
            end else begin
               cpix_d = cpix + CPIX_W'(1);
            end
            // c68 at its last count is exactly the cycle ce_68k is high
            if (pause_req && (c68 == C68_LAST)) begin
               state_d = PAUSED;
            end
         end

         PAUSED: begin
            if (!pause_req) begin
               state_d = RUN;
            end
         end

         default: state_d = STARTUP;
      endcase

      run_d      = (state_d == RUN);
      pix_last_d = mode_cur_d ? PIX_LAST_H40 : PIX_LAST_H32;
      ce_68k_d   = run_d && (c68_d == C68_LAST);
      ce_z80_d   = run_d && (cz80_d == CZ80_LAST);
      ce_psg_d   = run_d && (cz80_d == CZ80_LAST) && (cpsg_d == CPSG_LAST);
      ce_pix_d   = run_d && (cpix_d == pix_last_d);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= STARTUP;
         settle     <= '0;
         c68        <= '0;
         cz80       <= '0;
         cpsg       <= '0;
         cpix       <= '0;
         mode_cur   <= 1'b0;
         mode_nxt   <= 1'b0;
         core_reset <= 1'b1;
         paused     <= 1'b0;
         ce_68k     <= 1'b0;
         ce_z80     <= 1'b0;
         ce_psg     <= 1'b0;
         ce_pix     <= 1'b0;
      end else begin
         state      <= state_d;
         settle     <= settle_d;
         c68        <= c68_d;
         cz80       <= cz80_d;
         cpsg       <= cpsg_d;
         cpix       <= cpix_d;
         mode_cur   <= mode_cur_d;
         mode_nxt   <= mode_nxt_d;
         core_reset <= (state_d == STARTUP);
         paused     <= (state_d == PAUSED);
         ce_68k     <= ce_68k_d;
         ce_z80     <= ce_z80_d;
         ce_psg     <= ce_psg_d;
         ce_pix     <= ce_pix_d;
      end
   end

endmodule

// File: tb/tb_md_clk_enables.sv
// Bench for md_clk_enables: directed scenarios plus random pause/mode/reset traffic,
// all checked against a schedule-based reference model.
module tb_md_clk_enables;

   localparam int unsigned S      = 16;
   localparam int          LONG_N = 20000;

   logic clk;
   logic reset, h40, pause_req;
   logic core_reset, ce_68k, ce_z80, ce_psg, ce_pix, paused;

   md_clk_enables #(.STARTUP_CYCLES(S)) dut (
      .clk        (clk),
      .reset      (reset),
      .h40        (h40),
      .pause_req  (pause_req),
      .core_reset (core_reset),
      .ce_68k     (ce_68k),
      .ce_z80     (ce_z80),
      .ce_psg     (ce_psg),
      .ce_pix     (ce_pix),
      .paused     (paused)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: phase 0 startup, 1 run, 2 paused; m_a counts active cycles
   int   m_phase = 0;
   int   m_sc    = 0;
   int   m_a     = 0;
   int   m_due   = 0;
   bit   m_pend  = 1'b0;

   // obs = {core_reset, paused, ce_68k, ce_z80, ce_psg, ce_pix}
   logic [5:0] obs;
   logic [3:0] prev_ce = 4'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [5:0] model_out();
      logic [5:0] o;
      case (m_phase)
         0:       o = 6'b100000;
         1:       o = {1'b0, 1'b0, 1'(m_a % 7 == 6), 1'(m_a % 15 == 14),
                       1'(m_a % 240 == 239), 1'(m_a == m_due)};
         default: o = 6'b010000;
      endcase
      return o;
   endfunction

   task automatic model_step(input logic rst, input logic pr, input logic hm);
      if (rst) begin
         m_phase = 0;
         m_sc    = 0;
      end else begin
         case (m_phase)
            0: begin
               if (m_sc == int'(S) - 1) begin
                  m_phase = 1;
                  m_a     = 0;
                  m_pend  = hm;
                  m_due   = (hm ? 8 : 10) - 1;
               end else begin
                  m_sc++;
               end
            end
            1: begin
               if (m_a == m_due) begin
                  m_due  = m_a + (m_pend ? 8 : 10);
                  m_pend = hm;
               end
               if (pr && (m_a % 7 == 6)) m_phase = 2;
               m_a++;
            end
            default: if (!pr) m_phase = 1;
         endcase
      end
   endtask

   // Observe this cycle's outputs, then drive the inputs sampled at its closing edge
   task automatic tick(input logic rst, input logic pr, input logic hm);
      @(negedge clk);
      obs = {core_reset, paused, ce_68k, ce_z80, ce_psg, ce_pix};
      check("outputs", 32'(obs), 32'(model_out()));
      check("back_to_back", 32'(obs[3:0] & prev_ce), 32'(0));
      prev_ce   = obs[3:0];
      reset     = rst;
      pause_req = pr;
      h40       = hm;
      model_step(rst, pr, hm);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      int q68[$], qz80[$], qpsg[$], qpix[$];
      int fall, first_pause, fall2;
      int n68, nz80, npsg, npix;
      logic pr, hm, rst;

      reset     = 1'b1;
      pause_req = 1'b0;
      h40       = 1'b1;
      do_reset(3);

      // Startup sequence and H40 -> H32 switch at R+10
      fall = -1;
      for (int n = 0; n < int'(S) + 270; n++) begin
         tick(1'b0, 1'b0, 1'(n < int'(S) + 10));
         if (!obs[5] && fall < 0) fall = n;
         if (obs[3]) q68.push_back(n);
         if (obs[2]) qz80.push_back(n);
         if (obs[1]) qpsg.push_back(n);
         if (obs[0]) qpix.push_back(n);
      end
      check("core_reset_fall", 32'(fall), 32'(16));
      check("ce68_1", 32'(q68.size() > 0 ? q68[0] : -1), 32'(22));
      check("ce68_2", 32'(q68.size() > 1 ? q68[1] : -1), 32'(29));
      check("ce68_3", 32'(q68.size() > 2 ? q68[2] : -1), 32'(36));
      check("cez80_1", 32'(qz80.size() > 0 ? qz80[0] : -1), 32'(30));
      check("cez80_2", 32'(qz80.size() > 1 ? qz80[1] : -1), 32'(45));
      check("cepsg_1", 32'(qpsg.size() > 0 ? qpsg[0] : -1), 32'(255));
      check("cepix_1", 32'(qpix.size() > 0 ? qpix[0] : -1), 32'(23));
      check("cepix_2", 32'(qpix.size() > 1 ? qpix[1] : -1), 32'(31));
      check("cepix_3", 32'(qpix.size() > 2 ? qpix[2] : -1), 32'(39));
      check("cepix_4", 32'(qpix.size() > 3 ? qpix[3] : -1), 32'(49));

      // Short pause pulse, real pause, resume, then reset while paused
      do_reset(2);
      first_pause = -1;
      fall2       = -1;
      for (int n = 0; n <= 110; n++) begin
         pr  = 1'((n >= 17 && n <= 19) || (n >= 24 && n <= 48) || n >= 51);
         rst = 1'(n == 70);
         tick(rst, pr, 1'b1);
         if (obs[4] && first_pause < 0) first_pause = n;
         if (n > 71 && !obs[5] && fall2 < 0) fall2 = n;
         if (n == 29) check("pause_ce68_still", 32'(obs[3]), 32'(1));
         if (n == 49) check("paused_held", 32'(obs[4]), 32'(1));
         if (n == 50) check("resume_paused", 32'(obs[4]), 32'(0));
         if (n == 50) check("resume_z80_phase", 32'(obs[2]), 32'(1));
         if (n == 56) check("resume_ce68", 32'(obs[3]), 32'(1));
         if (n == 70) check("paused_before_reset", 32'(obs[4]), 32'(1));
         if (n == 71) check("reset_in_pause", 32'(obs), 32'(6'b100000));
      end
      check("first_pause", 32'(first_pause), 32'(30));
      check("restart_fall", 32'(fall2), 32'(87));

      // Random pause, mode and reset traffic
      do_reset(2);
      pr = 1'b0;
      hm = 1'b1;
      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(0, 19) == 0) pr = ~pr;
         if ($urandom_range(0, 59) == 0) hm = ~hm;
         rst = 1'($urandom_range(0, 2999) == 0);
         tick(rst, pr, hm);
      end

      // Long uninterrupted run: pulse totals
      do_reset(2);
      n68 = 0; nz80 = 0; npsg = 0; npix = 0;
      for (int n = 0; n < int'(S) + LONG_N; n++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (n >= int'(S)) begin
            n68  += int'(obs[3]);
            nz80 += int'(obs[2]);
            npsg += int'(obs[1]);
            npix += int'(obs[0]);
         end
      end
      check("long_ce68", 32'(n68), 32'(LONG_N / 7));
      check("long_cez80", 32'(nz80), 32'(LONG_N / 15));
      check("long_cepsg", 32'(npsg), 32'(LONG_N / 240));
      check("long_cepix", 32'(npix), 32'(LONG_N / 8));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
